mul8_share_sched: RTL and testbench



---
 rtl/mul8_sched_pkg.sv | 26 ++
 rtl/mul8_share_sched_rr_arb.sv | 40 ++++
 rtl/mul8_share_sched.sv | 128 ++++++++++++
 tb/tb_mul8_share_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_sched_pkg.sv
// Shared types and constants for the shared 8x8 multiplier scheduler.
// Stage records are sized for the largest supported requester count (16).
package mul8_sched_pkg;

    localparam int OPW      = 8;
    localparam int PRODW    = 16;
    localparam int TAGW_MAX = 4;
    localparam logic [PRODW-1:0] STATS_SAT = 16'hFFFF;

    typedef struct packed {
        logic [OPW-1:0]      a;
        logic [OPW-1:0]      b;
        logic [TAGW_MAX-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [PRODW-1:0]    product;
        logic [TAGW_MAX-1:0] tag;
    } s2_t;

    function automatic logic [PRODW-1:0] abs_diff(input logic [PRODW-1:0] x,
                                                  input logic [PRODW-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/mul8_share_sched_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above the pointer, with wrap.
// Latency: combinational grant; the pointer moves to winner+1 on the granting edge.
// Backpressure: en=0 suppresses every grant and holds the pointer.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int TAGW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [TAGW-1:0] gnt_idx
);

    logic [TAGW-1:0] ptr;
    logic            hit;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !hit && req[(int'(ptr) + k) % NREQ]) begin
                hit                          = 1'b1;
                gnt[(int'(ptr) + k) % NREQ]  = 1'b1;
                gnt_idx                      = TAGW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);
        end
    end

endmodule

// File: rtl/mul8_share_sched.sv
// Shares one external 8x8 multiplier core among NREQ requesters (MUL8_ERR_STATS_EN adds error stats).
// Latency: 2 edges from accept to rsp_valid; 1 result per cycle while rsp_ready is high.
// Backpressure: a stalled response freezes S2, then S1, and req_ready drops while S1 is held.
module mul8_share_sched
    import mul8_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic [OPW-1:0]      mul_a,
    output logic [OPW-1:0]      mul_b,
    input  logic [PRODW-1:0]    mul_o,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [TAGW-1:0]     rsp_tag,
    output logic [PRODW-1:0]    rsp_product
`ifdef MUL8_ERR_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [PRODW-1:0]    err_cnt,
    output logic [PRODW-1:0]    err_max
`endif
);

    s1_t             s1_q;
    s2_t             s2_q;
    logic            v1, v2;
    logic            s2_free, s1_adv, s1_free;
    logic [NREQ-1:0] gnt;
    logic [TAGW-1:0] gnt_idx;
    logic [OPW-1:0]  sel_a, sel_b;

    assign s2_free = !v2 || rsp_ready;
    assign s1_adv  = v1 && s2_free;
    assign s1_free = !v1 || s1_adv;

    rr_arb #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (s1_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (s1_free) begin
            v1 <= |gnt;
            if (|gnt) begin
                s1_q <= '{a: sel_a, b: sel_b, tag: TAGW_MAX'(gnt_idx)};
            end
        end
    end

    // The core is combinational from S1, so its product is captured on the S1->S2 move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2_q <= '0;
        end else if (s2_free) begin
            v2 <= v1;
            if (v1) begin
                s2_q <= '{product: mul_o, tag: s1_q.tag};
            end
        end
    end

    assign mul_a       = s1_q.a;
    assign mul_b       = s1_q.b;
    assign rsp_valid   = v2;
    assign rsp_tag     = s2_q.tag[TAGW-1:0];
    assign rsp_product = s2_q.product;

    generate
        if (TAGW < TAGW_MAX) begin : g_tag_pad
            logic tag_pad_unused;
            assign tag_pad_unused = ^s2_q.tag[TAGW_MAX-1:TAGW];
        end
    endgenerate

`ifdef MUL8_ERR_STATS_EN
    logic [PRODW-1:0] exact, err;

    assign exact = PRODW'(s1_q.a) * PRODW'(s1_q.b);
    assign err   = abs_diff(mul_o, exact);

    // Clear wins over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (stats_clr) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (s1_adv) begin
            if (err != '0 && err_cnt != STATS_SAT) begin
                err_cnt <= err_cnt + PRODW'(1);
            end
            if (err > err_max) begin
                err_max <= err;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul8_share_sched.sv
// Scoreboard bench: a predictor pushes expected results on each accept, a monitor pops and compares.
// The reference tracks items in flight as a queue and grants from a round-robin pointer model.
module tb_mul8_share_sched;

    localparam int NREQ = 4;
    localparam int TAGW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a, req_b;
    logic [7:0]        mul_a, mul_b;
    logic [15:0]       mul_o;
    logic              rsp_valid, rsp_ready;
    logic [TAGW-1:0]   rsp_tag;
    logic [15:0]       rsp_product;
`ifdef MUL8_ERR_STATS_EN
    logic              stats_clr;
    logic [15:0]       err_cnt, err_max;
`endif

    always #5 clk = ~clk;

    mul8_share_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_o       (mul_o),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_tag     (rsp_tag),
        .rsp_product (rsp_product)
`ifdef MUL8_ERR_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .err_cnt     (err_cnt),
        .err_max     (err_max)
`endif
    );

    // Core model: exact product, except the deliberately wrong 100*100 in the stats build.
    function automatic int core(input int a, input int b);
        int p;
        p = a * b;
`ifdef MUL8_ERR_STATS_EN
        if (a == 100 && b == 100) p = p + 3;
`endif
        return p;
    endfunction

    assign mul_o = 16'(core(int'(mul_a), int'(mul_b)));

    typedef struct {
        int tag;
        int a;
        int b;
        int prod;
        int acc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   mptr   = 0;
    bit   run    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Predictor: decides who should be granted and records accepted work.
    initial begin
        forever begin
            int              lane;
            int              j;
            logic [NREQ-1:0] exp_rdy;
            exp_t            e;
            @(negedge clk);
            if (run && rst_n) begin
                lane    = -1;
                exp_rdy = '0;
                for (int k = 0; k < NREQ; k++) begin
                    j = (mptr + k) % NREQ;
                    if (lane < 0 && req_valid[j]) lane = j;
                end
                if (lane >= 0 && !(q.size() == 2 && !rsp_ready)) exp_rdy[lane] = 1'b1;
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (exp_rdy != '0) begin
                    e.tag  = lane;
                    e.a    = int'(req_a[8*lane +: 8]);
                    e.b    = int'(req_b[8*lane +: 8]);
                    e.prod = core(e.a, e.b);
                    e.acc  = cyc + 1;
                    q.push_back(e);
                    mptr = (lane + 1) % NREQ;
                end
            end
        end
    end

    // Monitor: compares the presented response and the operands held for the core.
    initial begin
        forever begin
            bit vis;
            int nin;
            int s1i;
            @(negedge clk);
            #1;
            if (run && rst_n) begin
                vis = 1'b0;
                if (q.size() > 0) vis = (cyc > q[0].acc);
                check("rsp_valid", 32'(rsp_valid), 32'(vis));
                if (vis) begin
                    check("rsp_tag", 32'(rsp_tag), q[0].tag);
                    check("rsp_product", 32'(rsp_product), q[0].prod);
                end
                nin = 0;
                for (int i = 0; i < q.size(); i++) if (q[i].acc <= cyc) nin++;
                s1i = -1;
                if (nin == 2) s1i = 1;
                else if (nin == 1 && !vis) s1i = 0;
                if (s1i >= 0) begin
                    check("mul_a", 32'(mul_a), q[s1i].a);
                    check("mul_b", 32'(mul_b), q[s1i].b);
                end
                if (vis && rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lane(input int i, input int a, input int b);
        req_valid[i]     = 1'b1;
        req_a[8*i +: 8]  = 8'(a);
        req_b[8*i +: 8]  = 8'(b);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef MUL8_ERR_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) tick();
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_tag", 32'(rsp_tag), 0);
        check("reset_rsp_product", 32'(rsp_product), 0);
        check("reset_mul_a", 32'(mul_a), 0);
        check("reset_mul_b", 32'(mul_b), 0);
        check("reset_req_ready", 32'(req_ready), 0);
`ifdef MUL8_ERR_STATS_EN
        check("reset_err_cnt", 32'(err_cnt), 0);
        check("reset_err_max", 32'(err_max), 0);
`endif
        rst_n = 1'b1;
        run   = 1'b1;

        // Single request on lane 2: 13*11 = 143
        drive_lane(2, 13, 11);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // All lanes continuously valid
        for (int i = 0; i < NREQ; i++) drive_lane(i, 10 + i, 20 + i);
        repeat (8) tick();
        req_valid = '0;
        repeat (3) tick();

        // Backpressure after three back-to-back accepts
        drive_lane(0, 7, 9);
        drive_lane(1, 3, 250);
        repeat (3) tick();
        rsp_ready = 1'b0;
        repeat (5) tick();
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (4) tick();

        // Boundary operands
        drive_lane(0, 255, 255);
        tick();
        req_valid = '0;
        drive_lane(1, 0, 200);
        tick();
        req_valid = '0;
        repeat (4) tick();

`ifdef MUL8_ERR_STATS_EN
        drive_lane(0, 100, 100);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("err_max_after_mismatch", 32'(err_max), 3);
        check("err_cnt_after_mismatch", 32'(err_cnt), 1);
        drive_lane(0, 100, 100);
        tick();
        req_valid = '0;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("err_cnt_clr_priority", 32'(err_cnt), 0);
        check("err_max_clr_priority", 32'(err_max), 0);
        repeat (3) tick();
`endif

        // Fill both stages under stall, then reset mid-flight
        for (int i = 0; i < NREQ; i++) drive_lane(i, 30 + i, 40 + i);
        rsp_ready = 1'b0;
        repeat (4) tick();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 0);
        check("midreset_req_ready", 32'(req_ready), 0);
        q.delete();
        mptr = 0;
        repeat (2) tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive_lane(1, 5, 6);
        drive_lane(3, 8, 9);
        repeat (2) tick();
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic and response backpressure
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1)
                    drive_lane(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                else
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) tick();
        check("drain_empty", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
